// File: rtl/sort_pkg.sv
// Shared types for the BWT merge-sort datapath: element width and merge FSM states.
package sort_pkg;

    localparam int ELEM_W = 8;

    typedef logic [ELEM_W-1:0] byte_t;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        MERGE = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/sort_arrays_merge_select.sv
// Merge choice for one output slot: picks the smaller head element, left on ties.
module merge_select
    import sort_pkg::*;
(
    input  logic [7:0] l_val,
    input  logic [7:0] r_val,
    input  logic       l_empty,
    input  logic       r_empty,
    output logic [7:0] sel_val,
    output logic       take_left
);

    // An exhausted side always loses; ties go left to keep the merge stable.
    always_comb begin
        take_left = r_empty || (!l_empty && (l_val <= r_val));
        sel_val   = take_left ? l_val : r_val;
    end

endmodule

// File: rtl/sort_arrays.sv
// Sequential two-way merge: latches two ascending byte arrays, then emits one
// merged element per clock into merged_array and raises done when complete.
module sort_arrays
    import sort_pkg::*;
#(
    parameter int INPUT_ARR_LEN = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] array_L      [INPUT_ARR_LEN-1:0],
    input  logic [7:0] array_R      [INPUT_ARR_LEN-1:0],
    output logic [7:0] merged_array [2*INPUT_ARR_LEN-1:0],
    output logic       done
);

    localparam int N  = INPUT_ARR_LEN;
    localparam int IW = $clog2(N + 1);
    localparam int KW = $clog2(2 * N + 1);

    state_t        state;
    logic [IW-1:0] i;
    logic [IW-1:0] j;
    logic [KW-1:0] k;
    logic [7:0]    lr [N-1:0];
    logic [7:0]    rr [N-1:0];

    logic [7:0] l_cur;
    logic [7:0] r_cur;
    logic       l_empty;
    logic       r_empty;
    logic [7:0] sel_val;
    logic       take_left;

    // Head elements are read through a compare-mux so i/j may safely reach N.
    always_comb begin
        l_cur   = '0;
        r_cur   = '0;
        l_empty = (i == IW'(N));
        r_empty = (j == IW'(N));
        for (int idx = 0; idx < N; idx++) begin
            if (i == IW'(idx)) l_cur = lr[idx];
            if (j == IW'(idx)) r_cur = rr[idx];
        end
    end

    merge_select u_merge_select (
        .l_val     (l_cur),
        .r_val     (r_cur),
        .l_empty   (l_empty),
        .r_empty   (r_empty),
        .sel_val   (sel_val),
        .take_left (take_left)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= LOAD;
            i     <= '0;
            j     <= '0;
            k     <= '0;
            done  <= 1'b0;
            for (int s = 0; s < 2 * N; s++) merged_array[s] <= '0;
            for (int s = 0; s < N; s++) begin
                lr[s] <= '0;
                rr[s] <= '0;
            end
        end else begin
            case (state)
                LOAD: begin
                    for (int s = 0; s < N; s++) begin
                        lr[s] <= array_L[s];
                        rr[s] <= array_R[s];
                    end
                    state <= MERGE;
                end
                MERGE: begin
                    for (int s = 0; s < 2 * N; s++) begin
                        if (k == KW'(s)) merged_array[s] <= sel_val;
                    end
                    if (take_left) i <= i + IW'(1);
                    else           j <= j + IW'(1);
                    k <= k + KW'(1);
                    if (k == KW'(2 * N - 1)) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    // Result is held until the next reset; no automatic restart.
                    state <= DONE;
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_sort_arrays.sv
// Directed bench for sort_arrays (N=2): merge scenarios, latency, async reset.
module tb_sort_arrays;
    import sort_pkg::*;

    localparam int N = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] array_L      [N-1:0];
    logic [7:0] array_R      [N-1:0];
    logic [7:0] merged_array [2*N-1:0];
    logic       done;

    int vectors    = 0;
    int miscompares = 0;
    logic [7:0] exp_q[$];

    sort_arrays #(.INPUT_ARR_LEN(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .array_L      (array_L),
        .array_R      (array_R),
        .merged_array (merged_array),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Applies inputs, pulses reset for 10 ns and releases it on a falling edge.
    task automatic start_merge(input logic [7:0] l0, l1, r0, r1);
        @(negedge clk);
        array_L[0] = l0; array_L[1] = l1;
        array_R[0] = r0; array_R[1] = r1;
        rst = 1'b1;
        #10;
        rst = 1'b0;
    endtask

    // Counts rising edges until done, bounded by a cycle budget.
    task automatic wait_done(output int edges);
        edges = 0;
        while (!done && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if (done !== 1'b0) begin
            $display("FAIL reset_done: got %b want 0", done); miscompares++;
        end
        vectors++;
        if (dut.state !== LOAD) begin
            $display("FAIL reset_state: got %0d want %0d", dut.state, LOAD); miscompares++;
        end
        for (int s = 0; s < 2 * N; s++) begin
            vectors++;
            if (merged_array[s] !== 8'h00) begin
                $display("FAIL reset_merged[%0d]: got %h want 00", s, merged_array[s]); miscompares++;
            end
        end
    endtask

    task automatic test_chars;
        int edges;
        start_merge(8'h61, 8'h62, 8'h61, 8'h63);
        #1000;
        wait_done(edges);
        exp_q = '{8'h61, 8'h61, 8'h62, 8'h63};
        vectors++;
        if (done !== 1'b1) begin
            $display("FAIL chars_done: got %b want 1", done); miscompares++;
        end
        for (int s = 0; s < 2 * N; s++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            vectors++;
            if (merged_array[s] !== e) begin
                $display("FAIL chars_merged[%0d]: got %h want %h", s, merged_array[s], e); miscompares++;
            end
        end
    endtask

    task automatic test_left_drain;
        int edges;
        start_merge(8'd1, 8'd2, 8'd3, 8'd4);
        wait_done(edges);
        vectors++;
        if (edges !== 5 || done !== 1'b1) begin
            $display("FAIL left_latency: got %0d edges done=%b want 5 edges done=1", edges, done); miscompares++;
        end
        exp_q = '{8'd1, 8'd2, 8'd3, 8'd4};
        for (int s = 0; s < 2 * N; s++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            vectors++;
            if (merged_array[s] !== e) begin
                $display("FAIL left_merged[%0d]: got %h want %h", s, merged_array[s], e); miscompares++;
            end
        end
    endtask

    task automatic test_right_drain;
        int edges;
        start_merge(8'd5, 8'd9, 8'd1, 8'd2);
        wait_done(edges);
        vectors++;
        if (edges !== 5) begin
            $display("FAIL right_latency: got %0d want 5", edges); miscompares++;
        end
        exp_q = '{8'd1, 8'd2, 8'd5, 8'd9};
        for (int s = 0; s < 2 * N; s++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            vectors++;
            if (merged_array[s] !== e) begin
                $display("FAIL right_merged[%0d]: got %h want %h", s, merged_array[s], e); miscompares++;
            end
        end
        // Result must hold in DONE with no restart.
        repeat (6) @(posedge clk);
        #1;
        vectors++;
        if (merged_array[3] !== 8'd9 || done !== 1'b1) begin
            $display("FAIL right_hold: got %h done=%b want 09 done=1", merged_array[3], done); miscompares++;
        end
    endtask

    task automatic test_equal;
        int edges;
        start_merge(8'd7, 8'd7, 8'd7, 8'd7);
        @(posedge clk); #1;
        for (int p = 0; p < 2; p++) begin
            vectors++;
            if (dut.take_left !== 1'b1) begin
                $display("FAIL equal_take_left[%0d]: got %b want 1", p, dut.take_left); miscompares++;
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (dut.i !== 2'd2 || dut.j !== 2'd0) begin
            $display("FAIL equal_indices: got i=%0d j=%0d want i=2 j=0", dut.i, dut.j); miscompares++;
        end
        wait_done(edges);
        for (int s = 0; s < 2 * N; s++) begin
            vectors++;
            if (merged_array[s] !== 8'd7) begin
                $display("FAIL equal_merged[%0d]: got %h want 07", s, merged_array[s]); miscompares++;
            end
        end
    endtask

    task automatic test_unsigned;
        int edges;
        start_merge(8'h10, 8'hF0, 8'h80, 8'hFF);
        wait_done(edges);
        exp_q = '{8'h10, 8'h80, 8'hF0, 8'hFF};
        for (int s = 0; s < 2 * N; s++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            vectors++;
            if (merged_array[s] !== e) begin
                $display("FAIL unsigned_merged[%0d]: got %h want %h", s, merged_array[s], e); miscompares++;
            end
        end
    endtask

    task automatic test_reset_mid_merge;
        int edges;
        start_merge(8'd1, 8'd2, 8'd3, 8'd4);
        repeat (3) @(posedge clk);
        #1;
        exp_q = '{8'd1, 8'd2, 8'd0, 8'd0};
        for (int s = 0; s < 2 * N; s++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            vectors++;
            if (merged_array[s] !== e) begin
                $display("FAIL partial_merged[%0d]: got %h want %h", s, merged_array[s], e); miscompares++;
            end
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (done !== 1'b0) begin
            $display("FAIL midrst_done: got %b want 0", done); miscompares++;
        end
        for (int s = 0; s < 2 * N; s++) begin
            vectors++;
            if (merged_array[s] !== 8'h00) begin
                $display("FAIL midrst_merged[%0d]: got %h want 00", s, merged_array[s]); miscompares++;
            end
        end
        // New merge of fresh inputs; inputs scrambled after LOAD must not matter.
        start_merge(8'd5, 8'd9, 8'd1, 8'd2);
        repeat (2) @(posedge clk);
        #1;
        array_L[0] = 8'hAA; array_L[1] = 8'h00;
        array_R[0] = 8'h03; array_R[1] = 8'hEE;
        wait_done(edges);
        vectors++;
        if (done !== 1'b1) begin
            $display("FAIL restart_done: got %b want 1", done); miscompares++;
        end
        exp_q = '{8'd1, 8'd2, 8'd5, 8'd9};
        for (int s = 0; s < 2 * N; s++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            vectors++;
            if (merged_array[s] !== e) begin
                $display("FAIL restart_merged[%0d]: got %h want %h", s, merged_array[s], e); miscompares++;
            end
        end
    endtask

    initial begin
        for (int s = 0; s < N; s++) begin
            array_L[s] = 8'h00;
            array_R[s] = 8'h00;
        end
        test_reset;
        test_chars;
        test_left_drain;
        test_right_drain;
        test_equal;
        test_unsigned;
        test_reset_mid_merge;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
